sndglu_queued: RTL and testbench

Parametrised successor to the IIgs sound GLU. It sits between the 65816 host bus (four registers: control, data, address-low, address-high) and the DOC / sound-RAM bus. Host data accesses are posted into a FIFO, so back-to-back host writes do not stall. Queued accesses drain one per DOC slot and keep strict order between reads and writes.

---
 rtl/sndglu_queued.sv | 156 +++++++++++++++
 tb/tb_sndglu_queued.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sndglu_queued.sv
// sndglu_queued: IIgs sound GLU with posted host accesses drained one per DOC slot.
// Define SNDGLU_OVERFLOW_EN for a sticky FIFO overflow flag on control bit 4.
module sndglu_queued #(
    parameter int ADDR_W = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ph0_en,
    input  logic              slot_en,
    input  logic              select,
    input  logic              wr,
    input  logic [1:0]        host_addr,
    input  logic [7:0]        host_data_in,
    output logic [7:0]        host_data_out,
    input  logic [7:0]        sound_data_in,
    output logic [ADDR_W-1:0] sound_addr,
    output logic [7:0]        sound_data_out,
    output logic              bus_ram,
    output logic              ram_wr,
    output logic              doc_wr,
    output logic              bus_rd,
    output logic              ram_access,
    output logic [3:0]        volume,
    output logic              busy
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2;

    logic [1:0]        state;
    logic              auto_inc;
    logic              cur_rd;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        ptr_hi;
    logic [7:0]        read_data_reg;
    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [7:0]        q_data [FIFO_DEPTH];
    logic              q_ram  [FIFO_DEPTH];
    logic              q_rd   [FIFO_DEPTH];
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;
    logic [IDX_W:0]    count;
    logic              reg_wr;
    logic              push_req;
    logic              full;
    logic              pop;
    logic              push;
    logic              ovf_bit;

    assign reg_wr   = select & wr & ph0_en;
    assign push_req = select & ph0_en & (host_addr == 2'd1);
    assign full     = count == (IDX_W+1)'(FIFO_DEPTH);
    assign pop      = (state == IDLE) & slot_en & (count != '0);
    // a pop in the same clk frees the slot a full-FIFO push needs
    assign push     = push_req & (!full | pop);
    assign busy     = (count != '0) | (state != IDLE);
    assign ptr_hi   = 8'(ptr >> 8);

    assign ram_wr = (state == ISSUE) & bus_ram & !cur_rd;
    assign doc_wr = (state == ISSUE) & !bus_ram & !cur_rd;
    assign bus_rd = (state == ISSUE) & cur_rd;

`ifdef SNDGLU_OVERFLOW_EN
    logic ovf;
    always_ff @(posedge clk) begin
        if (reset)
            ovf <= 1'b0;
        else if (reg_wr & (host_addr == 2'd0))
            ovf <= 1'b0;
        else if (push_req & !push)
            ovf <= 1'b1;
    end
    assign ovf_bit = ovf;
`else
    assign ovf_bit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_access <= 1'b0;
            auto_inc   <= 1'b0;
            volume     <= 4'd0;
            ptr        <= '0;
        end else begin
            if (reg_wr & (host_addr == 2'd0)) begin
                ram_access <= host_data_in[6];
                auto_inc   <= host_data_in[5];
                volume     <= host_data_in[3:0];
            end
            if (reg_wr & (host_addr == 2'd2))
                ptr[7:0] <= host_data_in;
            else if (reg_wr & (host_addr == 2'd3))
                ptr <= {host_data_in[ADDR_W-9:0], ptr[7:0]};
            else if (push & auto_inc)
                ptr <= ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            host_data_out <= 8'd0;
        else if (select & !wr)
            host_data_out <= host_addr == 2'd0 ? {busy, ram_access, auto_inc, ovf_bit, volume} :
                             host_addr == 2'd1 ? read_data_reg :
                             host_addr == 2'd2 ? ptr[7:0] : ptr_hi;
    end

    // entries snapshot ptr and target at push time
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= ptr;
            q_data[tail] <= host_data_in;
            q_ram[tail]  <= ram_access;
            q_rd[tail]   <= !wr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + IDX_W'(1);
            if (pop)
                head <= head + IDX_W'(1);
            count <= count + (IDX_W+1)'(push) - (IDX_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sound_addr     <= '0;
            sound_data_out <= 8'd0;
            bus_ram        <= 1'b0;
            cur_rd         <= 1'b0;
            read_data_reg  <= 8'd0;
        end else if (state == IDLE) begin
            if (pop) begin
                sound_addr     <= q_addr[head];
                sound_data_out <= q_data[head];
                bus_ram        <= q_ram[head];
                cur_rd         <= q_rd[head];
                state          <= ISSUE;
            end
        end else if (state == ISSUE) begin
            state <= CAPTURE;
        end else begin
            if (cur_rd)
                read_data_reg <= sound_data_in;
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_sndglu_queued.sv
// tb_sndglu_queued: directed test of sndglu_queued posting, draining, overflow, wrap and reset.
module tb_sndglu_queued;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ph0_en = 1'b0;
    logic        slot_en = 1'b0;
    logic        select = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  host_addr = 2'd0;
    logic [7:0]  host_data_in = 8'd0;
    logic [7:0]  sound_data_in = 8'd0;
    logic [7:0]  host_data_out;
    logic [15:0] sound_addr;
    logic [7:0]  sound_data_out;
    logic        bus_ram, ram_wr, doc_wr, bus_rd, ram_access, busy;
    logic [3:0]  volume;
    int checks = 0;
    int errors = 0;
`ifdef SNDGLU_OVERFLOW_EN
    localparam logic [7:0] OVF_BIT = 8'h00;
`else
    localparam logic [7:0] OVF_BIT = 8'h10;
`endif

    sndglu_queued #(.ADDR_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .ph0_en(ph0_en), .slot_en(slot_en), .select(select), .wr(wr),
        .host_addr(host_addr), .host_data_in(host_data_in), .host_data_out(host_data_out),
        .sound_data_in(sound_data_in), .sound_addr(sound_addr), .sound_data_out(sound_data_out),
        .bus_ram(bus_ram), .ram_wr(ram_wr), .doc_wr(doc_wr), .bus_rd(bus_rd),
        .ram_access(ram_access), .volume(volume), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        select = 1'b1; wr = 1'b1; ph0_en = 1'b1; host_addr = a; host_data_in = d;
        tick();
        select = 1'b0; wr = 1'b0; ph0_en = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] a, input logic ph);
        select = 1'b1; wr = 1'b0; ph0_en = ph; host_addr = a;
        tick();
        select = 1'b0; ph0_en = 1'b0;
    endtask

    // one full slot: IDLE pop -> ISSUE (strobe) -> CAPTURE -> IDLE
    task automatic access(input logic [15:0] a, input logic [7:0] d, input logic ram,
                          input logic rd, input logic [7:0] rdata);
        slot_en = 1'b1;
        tick();
        slot_en = 1'b0;
        check($sformatf("strobe@%h", a), {ram_wr, doc_wr, bus_rd}, {ram & !rd, !ram & !rd, rd});
        check($sformatf("addr@%h", a), sound_addr, a);
        check($sformatf("target@%h", a), bus_ram, ram);
        if (!rd)
            check($sformatf("wdata@%h", a), sound_data_out, d);
        sound_data_in = rdata;
        tick();
        check($sformatf("strobe_off@%h", a), {ram_wr, doc_wr, bus_rd}, 3'b000);
        tick();
        sound_data_in = 8'd0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_strobes", {ram_wr, doc_wr, bus_rd}, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", sound_addr, 16'h0000);
        check("rst_wdata", sound_data_out, 8'h00);
        check("rst_ctrl", {bus_ram, ram_access, volume}, 6'd0);
        check("rst_hdo", host_data_out, 8'h00);
        host_read(2'd0, 1'b0);
        check("rst_reg0", host_data_out, OVF_BIT);

        // posted RAM writes with auto-increment
        host_write(2'd0, 8'h65);
        check("ctrl_ram", ram_access, 1'b1);
        check("ctrl_vol", volume, 4'h5);
        host_write(2'd0, 8'h60);
        host_write(2'd2, 8'h34);
        host_write(2'd3, 8'h12);
        for (int i = 0; i < 4; i++)
            host_write(2'd1, 8'hA0 + 8'(i));
        check("posted_busy", busy, 1'b1);
        host_read(2'd2, 1'b0);
        check("posted_ptr_lo", host_data_out, 8'h38);
        host_read(2'd3, 1'b0);
        check("posted_ptr_hi", host_data_out, 8'h12);
        host_read(2'd0, 1'b0);
        check("posted_reg0", host_data_out, 8'hE0 | OVF_BIT);
        for (int i = 0; i < 4; i++)
            access(16'h1234 + 16'(i), 8'hA0 + 8'(i), 1'b1, 1'b0, 8'h00);
        check("posted_idle", busy, 1'b0);

        // overflow: fifth push dropped, pointer held
        host_write(2'd2, 8'h00);
        host_write(2'd3, 8'h20);
        for (int i = 0; i < 5; i++)
            host_write(2'd1, 8'hB0 + 8'(i));
        host_read(2'd2, 1'b0);
        check("ovf_ptr", host_data_out, 8'h04);
        host_read(2'd0, 1'b0);
        check("ovf_reg0", host_data_out, 8'hF0);
        host_write(2'd0, 8'h60);
        host_read(2'd0, 1'b0);
        check("ovf_clear", host_data_out, 8'hE0 | OVF_BIT);
        for (int i = 0; i < 4; i++)
            access(16'h2000 + 16'(i), 8'hB0 + 8'(i), 1'b1, 1'b0, 8'h00);
        check("ovf_dropped", busy, 1'b0);

        // ordering: DOC write then prefetching reads
        host_write(2'd0, 8'h00);
        host_write(2'd2, 8'h40);
        host_write(2'd3, 8'h00);
        host_write(2'd1, 8'h55);
        host_read(2'd1, 1'b1);
        check("ord_first_rd", host_data_out, 8'h00);
        access(16'h0040, 8'h55, 1'b0, 1'b0, 8'h00);
        access(16'h0040, 8'h00, 1'b0, 1'b1, 8'h9A);
        host_read(2'd1, 1'b1);
        check("ord_second_rd", host_data_out, 8'h9A);
        access(16'h0040, 8'h00, 1'b0, 1'b1, 8'h3C);
        host_read(2'd1, 1'b0);
        check("ord_peek", host_data_out, 8'h3C);
        check("ord_no_push", busy, 1'b0);

        // pointer wrap
        host_write(2'd0, 8'h20);
        host_write(2'd2, 8'hFF);
        host_write(2'd3, 8'hFF);
        host_write(2'd1, 8'h77);
        host_read(2'd2, 1'b0);
        check("wrap_lo", host_data_out, 8'h00);
        host_read(2'd3, 1'b0);
        check("wrap_hi", host_data_out, 8'h00);
        access(16'hFFFF, 8'h77, 1'b0, 1'b0, 8'h00);

        // back-to-back slots: second one lands in ISSUE and is lost
        host_write(2'd1, 8'h11);
        host_write(2'd1, 8'h22);
        slot_en = 1'b1;
        tick();
        check("coll_first", {ram_wr, doc_wr, bus_rd}, 3'b010);
        check("coll_addr", sound_addr, 16'h0000);
        tick();
        slot_en = 1'b0;
        check("coll_capture", {ram_wr, doc_wr, bus_rd}, 3'b000);
        check("coll_addr_hold", sound_addr, 16'h0000);
        tick();
        check("coll_ignored", {ram_wr, doc_wr, bus_rd}, 3'b000);
        check("coll_busy", busy, 1'b1);
        access(16'h0001, 8'h22, 1'b0, 1'b0, 8'h00);
        check("coll_idle", busy, 1'b0);

        // push and pop in the same clk while full
        for (int i = 0; i < 4; i++)
            host_write(2'd1, 8'hC0 + 8'(i));
        select = 1'b1; wr = 1'b1; ph0_en = 1'b1; host_addr = 2'd1; host_data_in = 8'hC4; slot_en = 1'b1;
        tick();
        select = 1'b0; wr = 1'b0; ph0_en = 1'b0; slot_en = 1'b0;
        check("full_pop_strobe", {ram_wr, doc_wr, bus_rd}, 3'b010);
        check("full_pop_addr", sound_addr, 16'h0002);
        check("full_pop_data", sound_data_out, 8'hC0);
        tick();
        tick();
        for (int i = 1; i < 5; i++)
            access(16'h0002 + 16'(i), 8'hC0 + 8'(i), 1'b0, 1'b0, 8'h00);
        host_read(2'd2, 1'b0);
        check("full_pop_ptr", host_data_out, 8'h07);
        host_read(2'd0, 1'b0);
        check("full_pop_noovf", host_data_out, 8'h20 | OVF_BIT);

        // reset during ISSUE discards the queue
        host_write(2'd1, 8'h88);
        host_write(2'd1, 8'h99);
        slot_en = 1'b1;
        tick();
        slot_en = 1'b0;
        reset = 1'b1;
        check("rst_mid_issue", {ram_wr, doc_wr, bus_rd}, 3'b010);
        tick();
        check("rst_mid_strobes", {ram_wr, doc_wr, bus_rd}, 3'b000);
        check("rst_mid_busy", busy, 1'b0);
        reset = 1'b0;
        slot_en = 1'b1;
        tick();
        check("rst_mid_empty1", {ram_wr, doc_wr, bus_rd, busy}, 4'b0000);
        tick();
        slot_en = 1'b0;
        check("rst_mid_empty2", {ram_wr, doc_wr, bus_rd, busy}, 4'b0000);
        host_read(2'd2, 1'b0);
        check("rst_mid_ptr", host_data_out, 8'h00);
        host_read(2'd0, 1'b0);
        check("rst_mid_reg0", host_data_out, OVF_BIT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
